prvp_spi_slave_tx_ctrl: RTL and testbench
=========================================

// Module: prvp_spi_slave_tx_ctrl
// PURPOSE
//  Sequencer for the quad/single SPI slave transmit shifter. Runs one read-response
//  burst per start pulse: optional dummy cycles, then len_words 32-bit words pulled
//  from the read-data FIFO, back-to-back with no idle gap. Drives the shifter's
//  bit-count load (counter/counter_upd) and word load (data/data_valid); consumes its done.
//  Sits between the SPI slave command decoder/FIFO and the transmit shifter, both clocked by clk.
// PARAMETERS
//  LEN_W            16            width of len_words and words_sent
//  DUMMY_W          5             width of dummy_cycles
//  UNDERRUN_PATTERN 32'hDEAD_BEEF word shifted out when FIFO is empty at a word boundary
// PORTS
//  clk            in  1       shift clock (same edge as the transmit shifter)
//  rst            in  1       synchronous, active-high reset
//  abort          in  1       chip-select deasserted; synchronous abort to IDLE
//  start          in  1       one-cycle pulse; samples en_quad, len_words, dummy_cycles
//  en_quad        in  1       1: 4 bits/clk (8 clk/word), 0: 1 bit/clk (32 clk/word)
//  len_words      in  LEN_W   number of words in the burst
//  dummy_cycles   in  DUMMY_W idle clocks before the first word
//  fifo_data      in  32      read-data FIFO head
//  fifo_valid     in  1       FIFO head valid
//  fifo_ready     out 1       pop strobe; FIFO head consumed when fifo_valid&fifo_ready
//  tx_counter     out 8       shifter target count: 8'd7 quad, 8'd31 single
//  tx_counter_upd out 1       load tx_counter into shifter and start it
//  tx_data        out 32      word to shifter
//  tx_data_valid  out 1       load tx_data into shifter this cycle
//  tx_done        in  1       shifter at last count of current word (combinational from shifter)
//  busy           out 1       burst in progress (state != IDLE)
//  burst_done     out 1       one-cycle pulse at burst completion
//  underrun       out 1       sticky; set on any UNDERRUN_PATTERN substitution, cleared by start
//  words_sent     out LEN_W   words loaded into shifter this burst (incl. substitutions)
// BEHAVIOUR
//  Reset/abort: state IDLE; all outputs 0 except tx_counter=8'd7; underrun cleared
//   by rst only (abort keeps it). abort has priority over start and tx_done in the same cycle.
//  Latched at start: quad_q, len_q, dummy_q; underrun<=0, words_sent<=0. start ignored when busy.
//  IDLE  : start & len_words==0 -> burst_done next cycle, stays IDLE.
//          start & dummy_cycles!=0 -> DUMMY; else -> LOAD.
//  DUMMY : count dummy_q clocks (cycles 0..dummy_q-1), outputs idle; then -> LOAD.
//  LOAD  : tx_counter_upd=1, tx_counter=quad_q?7:31, tx_data_valid=1; tx_data=fifo_data
//          with fifo_ready=1 if fifo_valid, else UNDERRUN_PATTERN, fifo_ready=0, underrun<=1.
//          words_sent++; -> SHIFT.
//  SHIFT : wait for tx_done. On tx_done:
//          words_sent<len_q -> next word loaded in THIS cycle (tx_data_valid=1, same
//            fifo/underrun rule as LOAD, tx_counter_upd=0, words_sent++); stay SHIFT.
//          words_sent==len_q -> burst_done=1, -> IDLE.
//  Gapless: word period exactly tx_counter+1 clocks; no clock between words without a load.
//  fifo_ready only ever asserted in a cycle where tx_data_valid=1 and fifo_valid=1.
//  fifo_valid rising mid-word has no effect until the next boundary (no late insertion).
//  en_quad changes during a burst are ignored (quad_q used).
//  words_sent saturates at len_q; no wrap. len_words=2^LEN_W-1 supported.
//  busy=1 from cycle after start through the burst_done cycle.
// TESTING
//  1 single, len=1, dummy=0, FIFO holds 32'hA5A5_0F0F -> LOAD cycle has upd=1,counter=31,
//    data_valid=1, pop; tx_done 32 clk later -> burst_done, words_sent=1, underrun=0.
//  2 quad, len=4, dummy=3, FIFO full -> 3 idle clk, then 4 words loaded exactly 8 clk apart,
//    4 pops, burst_done on 4th tx_done, total 3+32 clk from LOAD span.
//  3 single, len=3, FIFO empty for word 2 -> words 1,3 from FIFO, word 2 = 32'hDEAD_BEEF,
//    no pop at word-2 boundary, underrun=1 stays set until next start.
//  4 quad, len=8, abort after 2.5 words -> IDLE next cycle, busy=0, no burst_done,
//    no further pops; following start runs normally.
//  5 start with len=0 -> burst_done one cycle later, no upd/data_valid/pop; start while
//    busy ignored; rst mid-burst -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/prvp_spi_slave_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prvp_spi_slave_tx_ctrl
//  Purpose  : Read-response burst sequencer for the quad/single SPI slave
//             transmit shifter. Inserts optional dummy clocks, then feeds
//             len_words 32-bit words from the read-data FIFO to the shifter
//             back-to-back. An empty FIFO at a word boundary is covered by a
//             fixed pattern word and flagged as a sticky underrun.
//  Revision : 1.0  initial release
// ============================================================================
module prvp_spi_slave_tx_ctrl #(
  parameter int          LEN_W            = 16,
  parameter int          DUMMY_W          = 5,
  parameter logic [31:0] UNDERRUN_PATTERN = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               start,
  input  logic               en_quad,
  input  logic [LEN_W-1:0]   len_words,
  input  logic [DUMMY_W-1:0] dummy_cycles,
  input  logic [31:0]        fifo_data,
  input  logic               fifo_valid,
  output logic               fifo_ready,
  output logic [7:0]         tx_counter,
  output logic               tx_counter_upd,
  output logic [31:0]        tx_data,
  output logic               tx_data_valid,
  input  logic               tx_done,
  output logic               busy,
  output logic               burst_done,
  output logic               underrun,
  output logic [LEN_W-1:0]   words_sent
);

  // Shifter terminal counts: 8 clocks per word in quad mode, 32 in single.
  localparam logic [7:0] C_CNT_QUAD   = 8'd7;
  localparam logic [7:0] C_CNT_SINGLE = 8'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMMY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               quad_q, quad_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DUMMY_W-1:0] dummy_q, dummy_d;
  logic [DUMMY_W-1:0] dummy_cnt_q, dummy_cnt_d;
  logic [LEN_W-1:0]   words_sent_q, words_sent_d;
  logic               underrun_q, underrun_d;
  logic               zero_len_done_q, zero_len_done_d;

  logic               w_kill;
  logic               w_last_word;
  logic               w_load_word;
  logic               w_first_load;
  logic               w_burst_end;

  // Next-state and word-load decode. abort (and rst) suppress every
  // same-cycle action so that no pop or load can slip out while the burst
  // is being torn down.
  always_comb begin
    state_d         = state_q;
    quad_d          = quad_q;
    len_d           = len_q;
    dummy_d         = dummy_q;
    dummy_cnt_d     = dummy_cnt_q;
    words_sent_d    = words_sent_q;
    underrun_d      = underrun_q;
    zero_len_done_d = 1'b0;
    w_load_word     = 1'b0;
    w_first_load    = 1'b0;
    w_burst_end     = 1'b0;
    w_kill          = abort | rst;
    // words_sent never exceeds len_q, so this also acts as the saturation guard
    w_last_word     = (words_sent_q >= len_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          quad_d       = en_quad;
          len_d        = len_words;
          dummy_d      = dummy_cycles;
          dummy_cnt_d  = '0;
          words_sent_d = '0;
          underrun_d   = 1'b0;
          if (len_words == '0) begin
            zero_len_done_d = 1'b1;
          end else if (dummy_cycles != '0) begin
            state_d = ST_DUMMY;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_DUMMY: begin
        if (dummy_cnt_q == (dummy_q - DUMMY_W'(1))) begin
          state_d = ST_LOAD;
        end else begin
          dummy_cnt_d = dummy_cnt_q + DUMMY_W'(1);
        end
      end

      ST_LOAD: begin
        w_load_word  = 1'b1;
        w_first_load = 1'b1;
        state_d      = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (tx_done) begin
          if (!w_last_word) begin
            // Reload on the shifter's last count keeps the stream gapless.
            w_load_word = 1'b1;
          end else begin
            w_burst_end = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_load_word) begin
      words_sent_d = words_sent_q + LEN_W'(1);
      if (!fifo_valid) begin
        underrun_d = 1'b1;
      end
    end

    if (w_kill) begin
      // Abort keeps underrun for post-mortem; rst clears it in the flop block.
      state_d         = ST_IDLE;
      quad_d          = 1'b1;
      words_sent_d    = '0;
      dummy_cnt_d     = '0;
      underrun_d      = underrun_q;
      zero_len_done_d = 1'b0;
      w_load_word     = 1'b0;
      w_first_load    = 1'b0;
      w_burst_end     = 1'b0;
    end
  end

  // Burst state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      quad_q          <= 1'b1;
      len_q           <= '0;
      dummy_q         <= '0;
      dummy_cnt_q     <= '0;
      words_sent_q    <= '0;
      underrun_q      <= 1'b0;
      zero_len_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      quad_q          <= quad_d;
      len_q           <= len_d;
      dummy_q         <= dummy_d;
      dummy_cnt_q     <= dummy_cnt_d;
      words_sent_q    <= words_sent_d;
      underrun_q      <= underrun_d;
      zero_len_done_q <= zero_len_done_d;
    end
  end

  // Shifter and FIFO handshake outputs. Loads must be combinational on
  // tx_done so the next word enters on the previous word's last count.
  always_comb begin
    tx_data_valid  = w_load_word;
    tx_counter_upd = w_first_load;
    fifo_ready     = w_load_word & fifo_valid;
    tx_data        = 32'd0;
    if (w_load_word) begin
      tx_data = fifo_valid ? fifo_data : UNDERRUN_PATTERN;
    end
    tx_counter = ((state_q != ST_IDLE) && !quad_q) ? C_CNT_SINGLE : C_CNT_QUAD;
  end

  // Status outputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    burst_done = w_burst_end | zero_len_done_q;
    underrun   = underrun_q;
    words_sent = words_sent_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_prvp_spi_slave_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prvp_spi_slave_tx_ctrl
//  Purpose  : Self-checking bench for prvp_spi_slave_tx_ctrl. Each burst is
//             planned on a cycle timeline from the burst arithmetic (load k at
//             start+1+dummy+k*period); expected loads go to a scoreboard queue
//             and a negedge monitor compares them as the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prvp_spi_slave_tx_ctrl;

  localparam int          LEN_W   = 16;
  localparam int          DUMMY_W = 5;
  localparam logic [31:0] UPAT    = 32'hDEAD_BEEF;
  localparam int          MAXC    = 40000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               abort = 1'b0;
  logic               start = 1'b0;
  logic               en_quad = 1'b0;
  logic [LEN_W-1:0]   len_words = '0;
  logic [DUMMY_W-1:0] dummy_cycles = '0;
  logic [31:0]        fifo_data = '0;
  logic               fifo_valid = 1'b0;
  logic               fifo_ready;
  logic [7:0]         tx_counter;
  logic               tx_counter_upd;
  logic [31:0]        tx_data;
  logic               tx_data_valid;
  logic               tx_done = 1'b0;
  logic               busy;
  logic               burst_done;
  logic               underrun;
  logic [LEN_W-1:0]   words_sent;

  prvp_spi_slave_tx_ctrl #(
    .LEN_W(LEN_W), .DUMMY_W(DUMMY_W), .UNDERRUN_PATTERN(UPAT)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort), .start(start), .en_quad(en_quad),
    .len_words(len_words), .dummy_cycles(dummy_cycles),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_done(tx_done),
    .busy(busy), .burst_done(burst_done), .underrun(underrun),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          upd;
    logic [7:0]  ctr;
    logic [31:0] data;
    bit          pop;
  } load_t;

  load_t       exp_q[$];
  load_t       mon_e;

  // Expected per-cycle status timeline.
  bit          exp_busy [MAXC];
  bit          exp_bd   [MAXC];
  bit          exp_und  [MAXC];
  bit          exp_c7   [MAXC];
  int          exp_ws   [MAXC];
  // Stimulus timeline.
  bit          drv_start[MAXC];
  bit          drv_quad [MAXC];
  bit          drv_abort[MAXC];
  bit          drv_rst  [MAXC];
  bit          drv_done [MAXC];
  int          drv_len  [MAXC];
  int          drv_dummy[MAXC];
  int          drv_fv   [MAXC];   // 0 random, 1 force valid, 2 force empty
  logic [31:0] drv_fdata[MAXC];

  int cyc    = -1;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic paint_und(input int from, input bit val);
    for (int c = from; c < MAXC; c++) exp_und[c] = val;
  endtask

  task automatic paint_ws(input int from, input int val);
    for (int c = from; c < MAXC; c++) exp_ws[c] = val;
  endtask

  // Plan one burst starting at cycle s. k_rel>0 kills the burst at cycle
  // s+1+d+k_rel (kind 1 abort, 2 rst). Returns the last cycle worth running.
  task automatic plan_burst(input int s, input bit q, input int len, input int d,
                            input logic [7:0] gmask, input int gap_pct,
                            input bit use_fd, input logic [31:0] fd,
                            input int k_rel, input int kind, output int last);
    int   n, l0, endc, lim, kc, lk, hi;
    bit   gap;
    logic [31:0] data;
    n    = q ? 8 : 32;
    l0   = s + 1 + d;
    endc = (len == 0) ? s + 1 : l0 + len * n;
    kc   = (k_rel > 0) ? l0 + k_rel : 0;
    lim  = (kc > 0) ? kc : MAXC;
    drv_start[s] = 1'b1;
    drv_quad[s]  = q;
    drv_len[s]   = len;
    drv_dummy[s] = d;
    paint_und(s + 1, 1'b0);
    paint_ws(s + 1, 0);
    if (len == 0) begin
      exp_bd[s + 1] = 1'b1;
      last = s + 2;
      return;
    end
    for (int c = s + 1; c <= endc && c <= lim && c < MAXC; c++) exp_busy[c] = 1'b1;
    for (int k = 0; k < len; k++) begin
      lk = l0 + k * n;
      if (lk >= lim || lk >= MAXC) break;
      gap = (k < 8) ? gmask[k] : 1'b0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) gap = 1'b1;
      data = (k == 0 && use_fd) ? fd : $urandom;
      exp_q.push_back('{cyc: lk, upd: (k == 0), ctr: (q ? 8'd7 : 8'd31),
                        data: (gap ? UPAT : data), pop: !gap});
      drv_fv[lk]    = gap ? 2 : 1;
      drv_fdata[lk] = data;
      if (gap) paint_und(lk + 1, 1'b1);
      paint_ws(lk + 1, k + 1);
      if (lk + n <= lim && lk + n < MAXC) drv_done[lk + n] = 1'b1;
    end
    if (endc < lim && endc < MAXC) exp_bd[endc] = 1'b1;
    // A start while busy must be ignored.
    hi = (endc < lim - 1) ? endc : lim - 1;
    if (hi >= s + 1) begin
      int ic;
      ic = $urandom_range(s + 1, hi);
      drv_start[ic] = 1'b1;
      drv_quad[ic]  = 1'($urandom_range(0, 1));
      drv_len[ic]   = $urandom_range(0, 7);
      drv_dummy[ic] = $urandom_range(0, 31);
    end
    if (kc > 0) begin
      if (kind == 1) drv_abort[kc] = 1'b1;
      else           drv_rst[kc]   = 1'b1;
      paint_ws(kc + 1, 0);
      if (kind == 2) paint_und(kc + 1, 1'b0);
      exp_c7[kc + 1] = 1'b1;
      last = kc + 1;
    end else begin
      last = endc + 1;
    end
  endtask

  // Advance one clock and apply this cycle's planned inputs.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget cyc=%0d actual=overrun required=<%0d", cyc, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    #1;
    rst     = drv_rst[cyc];
    abort   = drv_abort[cyc];
    start   = drv_start[cyc];
    tx_done = drv_done[cyc];
    if (drv_start[cyc]) begin
      en_quad      = drv_quad[cyc];
      len_words    = LEN_W'(drv_len[cyc]);
      dummy_cycles = DUMMY_W'(drv_dummy[cyc]);
    end else begin
      en_quad      = 1'($urandom_range(0, 1));
      len_words    = LEN_W'($urandom);
      dummy_cycles = DUMMY_W'($urandom);
    end
    case (drv_fv[cyc])
      1:       begin fifo_valid = 1'b1; fifo_data = drv_fdata[cyc]; end
      2:       begin fifo_valid = 1'b0; fifo_data = $urandom; end
      default: begin fifo_valid = 1'($urandom_range(0, 1)); fifo_data = $urandom; end
    endcase
  endtask

  task automatic run(input bit q, input int len, input int d, input logic [7:0] gmask,
                     input int gap_pct, input bit use_fd, input logic [31:0] fd,
                     input int k_rel, input int kind);
    int last, idle;
    plan_burst(cyc + 1, q, len, d, gmask, gap_pct, use_fd, fd, k_rel, kind, last);
    while (cyc < last) tick();
    idle = $urandom_range(0, 3);
    repeat (idle) tick();
  endtask

  // Monitor: status timeline every cycle, scoreboard pop on each load.
  always @(negedge clk) begin
    if (cyc >= 0 && cyc < MAXC) begin
      chk("busy",       32'(busy),       32'(exp_busy[cyc]));
      chk("burst_done", 32'(burst_done), 32'(exp_bd[cyc]));
      chk("underrun",   32'(underrun),   32'(exp_und[cyc]));
      chk("words_sent", 32'(words_sent), exp_ws[cyc]);
      if (exp_c7[cyc]) chk("idle_tx_counter", 32'(tx_counter), 32'd7);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_load", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        chk("load_valid", 32'(tx_data_valid), 32'd1);
        if (tx_data_valid) begin
          chk("load_upd",     32'(tx_counter_upd), 32'(mon_e.upd));
          if (mon_e.upd) chk("load_counter", 32'(tx_counter), 32'(mon_e.ctr));
          chk("load_data",    tx_data,             mon_e.data);
          chk("load_pop",     32'(fifo_ready),     32'(mon_e.pop));
        end
      end else begin
        chk("spurious_valid", 32'(tx_data_valid),  32'd0);
        chk("spurious_upd",   32'(tx_counter_upd), 32'd0);
        chk("spurious_pop",   32'(fifo_ready),     32'd0);
      end
    end
  end

  initial begin
    int q, len, d, n, kr, kind, r;
    drv_rst[0] = 1'b1;
    drv_rst[1] = 1'b1;
    exp_c7[0]  = 1'b1;
    exp_c7[1]  = 1'b1;
    exp_c7[2]  = 1'b1;
    repeat (3) tick();

    // single word, single mode, known FIFO word
    run(1'b0, 1, 0, 8'h00, 0, 1'b1, 32'hA5A5_0F0F, 0, 0);
    // quad, 4 words, 3 dummy clocks
    run(1'b1, 4, 3, 8'h00, 0, 1'b0, 32'h0, 0, 0);
    // single, 3 words, FIFO empty at word 2
    run(1'b0, 3, 1, 8'h02, 0, 1'b0, 32'h0, 0, 0);
    // quad, 8 words, abort after 2.5 words, then a normal burst
    run(1'b1, 8, 0, 8'h00, 0, 1'b0, 32'h0, 20, 1);
    run(1'b1, 2, 2, 8'h00, 0, 1'b0, 32'h0, 0, 0);
    // zero-length bursts
    run(1'b0, 0, 0, 8'h00, 0, 1'b0, 32'h0, 0, 0);
    run(1'b1, 0, 7, 8'h00, 0, 1'b0, 32'h0, 0, 0);
    // underrun then abort keeps underrun; rst mid-burst clears everything
    run(1'b1, 4, 0, 8'h01, 0, 1'b0, 32'h0, 12, 1);
    run(1'b0, 3, 2, 8'h01, 0, 1'b0, 32'h0, 40, 2);
    run(1'b0, 2, 0, 8'h00, 0, 1'b0, 32'h0, 0, 0);
    // maximum length, aborted after a few words
    run(1'b1, (1 << LEN_W) - 1, 0, 8'h00, 0, 1'b0, 32'h0, 28, 1);

    // randomized bursts
    for (int i = 0; i < 25; i++) begin
      q    = $urandom_range(0, 1);
      len  = $urandom_range(1, 5);
      d    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
      n    = q ? 8 : 32;
      kr   = 0;
      kind = 0;
      r    = $urandom_range(0, 9);
      if (r == 0) begin
        kind = 1;
        kr   = $urandom_range(1, len * n - 1);
      end else if (r == 1) begin
        kind = 2;
        kr   = $urandom_range(1, len * n - 2);
        if (kr % n == 0) kr++;
      end
      run(q[0], len, d, 8'h00, 20, 1'b0, 32'h0, kr, kind);
    end

    repeat (4) tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
